// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bus between the host environment
// and program_loader. The loader sits on the slave modport: it consumes the rx
// byte stream and drives the memory write port. The master modport is the
// environment side: it produces bytes and observes the writes.
interface program_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [11:0] mem_address;
  logic [15:0] mem_data_in;
  logic        mem_write_enable;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_address, mem_data_in, mem_write_enable
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_address, mem_data_in, mem_write_enable
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed big-endian byte stream and writes
// it as 16-bit words into instruction memory, holding the cpu in reset until
// the load completes.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes (CHECK state).
module program_loader (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  program_loader_if.slave        bus,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [12:0]            words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_t;

  state_t      state_q, state_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [12:0] words_q, words_d;
  logic [12:0] count_q, count_d;
  logic [7:0]  hi_q, hi_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        rx_ready;
  logic        xfer;
  logic        go_end;
  logic [15:0] hdr;

  // Status decodes of the state register.
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      HDR_HI, HDR_LO, DATA_HI, DATA_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      default: begin
        rx_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  assign xfer = bus.rx_valid & rx_ready;
  assign hdr  = {hi_q, bus.rx_data};

  // Next-state and next-output logic for the load sequence.
  always_comb begin
    state_d     = state_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    words_d     = words_q;
    count_d     = count_q;
    hi_d        = hi_q;
    go_end      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (start && (state_q == IDLE || state_q == DONE || state_q == ERROR)) begin
      state_d     = HDR_HI;
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
      error_d     = 1'b0;
      words_d     = 13'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_d      = 8'd0;
`endif
    end else begin
      case (state_q)
        HDR_HI: if (xfer) begin
          hi_d    = bus.rx_data;
          state_d = HDR_LO;
        end
        HDR_LO: if (xfer) begin
          if (hdr > 16'd4096) begin
            state_d     = ERROR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
          end else if (hdr == 16'd0) begin
            go_end = 1'b1;
          end else begin
            count_d = hdr[12:0];
            state_d = DATA_HI;
          end
        end
        DATA_HI: if (xfer) begin
          hi_d    = bus.rx_data;
          state_d = DATA_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_data;
`endif
        end
        DATA_LO: if (xfer) begin
          // Write is registered so it appears the cycle after the low byte.
          we_d    = 1'b1;
          addr_d  = words_q[11:0];
          data_d  = {hi_q, bus.rx_data};
          words_d = words_q + 13'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_data;
`endif
          if (words_q + 13'd1 == count_q) go_end = 1'b1;
          else                            state_d = DATA_HI;
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: if (xfer) begin
          if (bus.rx_data == csum_q) begin
            state_d     = DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d     = ERROR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
      if (go_end) begin
`ifdef LOADER_CHECKSUM_EN
        state_d     = CHECK;
`else
        state_d     = DONE;
        done_d      = 1'b1;
        cpu_reset_d = 1'b0;
`endif
      end
    end
  end

  // Control and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 12'd0;
      data_q      <= 16'd0;
      words_q     <= 13'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      words_q     <= words_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Header/high-byte holding registers; only read after being loaded.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    hi_q    <= hi_d;
  end

  // A strobe registered just before reset is masked so reset wins that cycle.
  assign bus.mem_write_enable = we_q & ~reset;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data_in      = data_q;
  assign bus.rx_ready         = rx_ready;
  assign cpu_reset            = cpu_reset_q;
  assign done                 = done_q;
  assign error                = error_q;
  assign words_loaded         = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed cases plus randomized loads checked
// against a stream-level reference model. Honours LOADER_CHECKSUM_EN.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cpu_reset, busy, done, error;
  logic [12:0] words_loaded;

  program_loader_if bus();

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [27:0] wr_q[$];     // {address, data} of every observed write
  logic [7:0]  byte_q[$];   // bytes to send
  logic [15:0] word_q[$];   // program words for the current load

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_write_enable) wr_q.push_back({bus.mem_address, bus.mem_data_in});
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Send byte_q with random idle gaps (gap = percent chance of a bubble).
  task automatic send_bytes(input int gap);
    int idx = 0;
    int guard = 0;
    while (idx < byte_q.size() && guard < 20000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(99) < gap) begin
        bus.rx_valid = 1'b0;
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = byte_q[idx];
      end
      if (bus.rx_valid && bus.rx_ready) idx++;
    end
    @(negedge clk) bus.rx_valid = 1'b0;
    check("rx_bytes_accepted", idx, byte_q.size());
  endtask

  task automatic run_load(input logic [15:0] hdr, input bit cs_force_en,
                          input logic [7:0] cs_force, input int gap, input bit mid_start);
    logic [7:0] cs;
    int         n_exp;
    bit         exp_err;
    wr_q.delete();
    pulse_start();
    check("start_busy", busy, 1);
    check("start_cpu_reset", cpu_reset, 1);
    check("start_done", done, 0);
    check("start_error", error, 0);
    check("start_words", words_loaded, 0);
    check("start_rx_ready", bus.rx_ready, 1);

    byte_q.delete();
    byte_q.push_back(hdr[15:8]);
    byte_q.push_back(hdr[7:0]);
    send_bytes(gap);
    if (mid_start) begin
      check("mid_busy", busy, 1);
      pulse_start();
    end

    cs = 8'd0;
    byte_q.delete();
    if (hdr <= 16'd4096) begin
      for (int i = 0; i < int'(hdr); i++) begin
        byte_q.push_back(word_q[i][15:8]);
        byte_q.push_back(word_q[i][7:0]);
        cs = cs ^ word_q[i][15:8] ^ word_q[i][7:0];
      end
`ifdef LOADER_CHECKSUM_EN
      byte_q.push_back(cs_force_en ? cs_force : cs);
`endif
    end
    if (byte_q.size() > 0) send_bytes(gap);
    repeat (2) @(negedge clk);

    exp_err = (hdr > 16'd4096);
`ifdef LOADER_CHECKSUM_EN
    if (!exp_err && cs_force_en && cs_force != cs) exp_err = 1'b1;
`endif
    n_exp = (hdr > 16'd4096) ? 0 : int'(hdr);
    check("end_done", done, !exp_err);
    check("end_error", error, exp_err);
    check("end_cpu_reset", cpu_reset, exp_err);
    check("end_busy", busy, 0);
    check("end_rx_ready", bus.rx_ready, 0);
    check("end_words", words_loaded, n_exp);
    check("n_writes", wr_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
      check("wr_addr", wr_q[i][27:16], i);
      check("wr_data", wr_q[i][15:0], word_q[i]);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_loaded, 0);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_we", bus.mem_write_enable, 0);
    check("rst_addr", bus.mem_address, 0);
    check("rst_data", bus.mem_data_in, 0);
    @(posedge clk) #1 reset = 1'b0;

    // Two-word reference load, back-to-back bytes.
    word_q = '{16'h1234, 16'hABCD};
    run_load(16'd2, 1'b0, 8'h00, 0, 1'b0);
    // Wrong trailing byte (only meaningful with checksum enabled).
    run_load(16'd2, 1'b1, 8'h00, 0, 1'b0);
    // Oversized header, then empty program.
    run_load(16'h1001, 1'b0, 8'h00, 0, 1'b0);
    run_load(16'd0, 1'b0, 8'h00, 0, 1'b0);
    // start during DATA_HI is ignored.
    word_q = '{16'h0F0F, 16'h5AA5, 16'h8001};
    run_load(16'd3, 1'b0, 8'h00, 30, 1'b1);

    // Reset right after the low byte of word 0: pending strobe is masked.
    wr_q.delete();
    pulse_start();
    byte_q = '{8'h00, 8'h01, 8'h11};
    send_bytes(0);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h22;
    @(posedge clk) #1;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("rstmid_we", bus.mem_write_enable, 0);
    @(posedge clk) #1 reset = 1'b0;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_cpu_reset", cpu_reset, 1);
    check("rstmid_rx_ready", bus.rx_ready, 0);
    check("rstmid_words", words_loaded, 0);
    check("rstmid_writes", wr_q.size(), 0);

    // Randomized loads, including occasional bad header or checksum.
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 16);
      word_q.delete();
      for (int i = 0; i < n; i++) word_q.push_back(16'($urandom));
      if ($urandom_range(9) == 0)
        run_load({8'($urandom_range(17, 255)), 8'($urandom)}, 1'b0, 8'h00, 20, 1'b0);
      else
        run_load(16'(n), ($urandom_range(4) == 0), 8'($urandom), $urandom_range(60), 1'b0);
    end

    // Largest legal program.
    word_q.delete();
    for (int i = 0; i < 4096; i++) word_q.push_back(16'($urandom));
    run_load(16'd4096, 1'b0, 8'h00, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
